// File: rtl/axis_frame_rr_arbiter_pkg.sv
// Shared types and constants for the frame-granular round-robin AXI4-Stream arbiter.
// The optional per-source frame counters are enabled by AXIS_ARB_FRAME_COUNT_EN.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int FRAME_CNT_W = 32;

  // Successor of idx, modulo n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 32'sd1 >= n) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/axis_frame_rr_arbiter_if.sv
// Bundled stream, grant and optional counter signals of the arbiter.
// The slave modport is the arbiter side; the master modport is the surrounding environment.
interface axis_frame_rr_arbiter_if
  import axis_arb_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = ((DATA_WIDTH + 7) / 8),
  parameter int USER_WIDTH = 1,
  parameter int IDX_WIDTH  = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
);
  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [S_COUNT-1:0]            s_axis_tvalid;
  logic [S_COUNT-1:0]            s_axis_tready;
  logic [S_COUNT-1:0]            s_axis_tlast;
  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic                          m_axis_tlast;
  logic [IDX_WIDTH-1:0]          m_axis_tid;
  logic [USER_WIDTH-1:0]         m_axis_tuser;
  logic                          grant_valid;
  logic [IDX_WIDTH-1:0]          grant_index;
`ifdef AXIS_ARB_FRAME_COUNT_EN
  logic [S_COUNT*FRAME_CNT_W-1:0] frame_count;
`endif

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    output m_axis_tuser, grant_valid, grant_index
`ifdef AXIS_ARB_FRAME_COUNT_EN
    , output frame_count
`endif
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    input  m_axis_tuser, grant_valid, grant_index
`ifdef AXIS_ARB_FRAME_COUNT_EN
    , input frame_count
`endif
  );

endinterface

// File: rtl/axis_frame_rr_arbiter_rr_select.sv
// Round-robin requester search: first set request at or after i_base, wrapping modulo S_COUNT.
// Built as a priority encoder over the request vector duplicated and masked below i_base.
module arb_rr_select
  import axis_arb_pkg::*;
#(
  parameter int S_COUNT   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [S_COUNT-1:0]   i_req,
  input  logic [IDX_WIDTH-1:0] i_base,
  output logic                 o_found,
  output logic [IDX_WIDTH-1:0] o_idx
);

  logic [2*S_COUNT-1:0] w_hit;
  int                   w_pos;

  // Mask off the lower copy below the base, then take the lowest remaining hit.
  always_comb begin
    w_hit = {i_req, i_req};
    for (int j = 0; j < S_COUNT; j++) begin
      w_hit[j] = i_req[j] & (j >= int'(i_base));
    end
    w_pos = 32'sd0;
    for (int j = 2 * S_COUNT - 1; j >= 0; j--) begin
      w_pos = w_hit[j] ? j : w_pos;
    end
    o_found = |w_hit;
    o_idx   = IDX_WIDTH'((w_pos >= S_COUNT) ? (w_pos - S_COUNT) : w_pos);
  end

endmodule

// File: rtl/axis_frame_rr_arbiter.sv
// Frame-granular round-robin arbiter sharing one AXI4-Stream sink between S_COUNT sources.
// Define AXIS_ARB_FRAME_COUNT_EN to add per-source accepted-frame counters (frame_count).
module axis_frame_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter int USER_WIDTH  = 1,
  parameter int LAST_ENABLE = 1,
  parameter int IDX_WIDTH   = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input logic                    clk,
  input logic                    rst,
  axis_frame_rr_arbiter_if.slave bus
);

  arb_state_t           r_state;
  logic                 r_grant_valid;
  logic [IDX_WIDTH-1:0] r_grant_index;
  logic [IDX_WIDTH-1:0] r_ptr;
  logic [IDX_WIDTH-1:0] w_sel;
  logic                 w_found;
  logic                 w_m_tvalid;
  logic                 w_m_tlast;
  logic                 w_accept;
  logic                 w_last_acc;

  arb_rr_select #(
    .S_COUNT  (S_COUNT),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_sel (
    .i_req  (bus.s_axis_tvalid),
    .i_base (r_ptr),
    .o_found(w_found),
    .o_idx  (w_sel)
  );

  // Pass-through of the granted stream; only the granted source sees the sink's ready.
  always_comb begin
    w_m_tvalid        = 1'b0;
    bus.s_axis_tready = {S_COUNT{1'b0}};
    if (r_state == ARB_GRANT) begin
      w_m_tvalid        = bus.s_axis_tvalid[r_grant_index];
      bus.s_axis_tready = bus.m_axis_tready ?
                          ({{(S_COUNT-1){1'b0}}, 1'b1} << r_grant_index) : {S_COUNT{1'b0}};
    end else begin
      w_m_tvalid        = 1'b0;
      bus.s_axis_tready = {S_COUNT{1'b0}};
    end
    w_m_tlast = (LAST_ENABLE != 0) ? bus.s_axis_tlast[r_grant_index] : 1'b1;
  end

  assign w_accept          = w_m_tvalid & bus.m_axis_tready;
  assign w_last_acc        = w_accept & w_m_tlast;
  assign bus.m_axis_tdata  = bus.s_axis_tdata[r_grant_index*DATA_WIDTH +: DATA_WIDTH];
  assign bus.m_axis_tkeep  = bus.s_axis_tkeep[r_grant_index*KEEP_WIDTH +: KEEP_WIDTH];
  assign bus.m_axis_tuser  = bus.s_axis_tuser[r_grant_index*USER_WIDTH +: USER_WIDTH];
  assign bus.m_axis_tvalid = w_m_tvalid;
  assign bus.m_axis_tlast  = w_m_tlast;
  assign bus.m_axis_tid    = r_grant_index;
  assign bus.grant_valid   = r_grant_valid;
  assign bus.grant_index   = r_grant_index;

  // Arbitration FSM; r_ptr holds where the next search starts (0 after reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ARB_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_index <= {IDX_WIDTH{1'b0}};
      r_ptr         <= {IDX_WIDTH{1'b0}};
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_state       <= ARB_GRANT;
            r_grant_valid <= 1'b1;
            r_grant_index <= w_sel;
            r_ptr         <= IDX_WIDTH'(rr_next(int'(w_sel), S_COUNT));
          end
        end
        ARB_GRANT: begin
          if (w_last_acc) begin
            r_state       <= ARB_IDLE;
            r_grant_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= ARB_IDLE;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIS_ARB_FRAME_COUNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt [S_COUNT];

  // Count accepted tlast beats per source; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < S_COUNT; i++) begin
        r_frame_cnt[i] <= {FRAME_CNT_W{1'b0}};
      end
    end else if (w_last_acc) begin
      r_frame_cnt[r_grant_index] <= r_frame_cnt[r_grant_index] + FRAME_CNT_W'(1);
    end
  end

  // Flatten the counter array onto the port.
  always_comb begin
    bus.frame_count = {(S_COUNT*FRAME_CNT_W){1'b0}};
    for (int i = 0; i < S_COUNT; i++) begin
      bus.frame_count[i*FRAME_CNT_W +: FRAME_CNT_W] = r_frame_cnt[i];
    end
  end
`endif

endmodule
